// File: rtl/disp_scheduler.sv
// disp_scheduler: two-requester owner arbiter for a 4-digit multiplexed BCD display
// with frame-aligned handover, hold-off preemption and leading-zero blanking.
module disp_scheduler #(
    parameter int SCAN_DIV    = 32,
    parameter int HOLD_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic        blank_en,
    output logic [1:0]  gnt,
    output logic [3:0]  select,
    output logic [3:0]  segment,
    output logic        frame_end
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t      state_q;
    logic [15:0] cnt_q, shadow_q;
    logic [3:0]  sel_q, hold_q, hold_d;
    logic [1:0]  gnt_q;
    logic        ptr_q, tick, own_id, pick, keep, take, nxt, b3, b2, b1;
    assign tick      = cnt_q == 16'(SCAN_DIV - 1);
    assign frame_end = tick && sel_q == 4'b0001;
    assign own_id    = state_q == OWN1;
    assign pick      = req == 2'b11 ? ptr_q : req[1];
    // the frame that is ending counts toward the hold before the preemption decision
    assign hold_d    = hold_q == 4'(HOLD_FRAMES) ? hold_q : hold_q + 4'd1;
    assign keep      = req[own_id] && !(req[!own_id] && hold_d == 4'(HOLD_FRAMES));
    assign take      = state_q == IDLE ? req != 2'b00 : frame_end && !keep && req[!own_id];
    assign nxt       = state_q == IDLE ? pick : !own_id;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sel_q    <= '0;
            state_q  <= IDLE;
            gnt_q    <= '0;
            shadow_q <= '0;
            hold_q   <= '0;
            ptr_q    <= 1'b0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 16'd1;
            if (tick)
                sel_q <= sel_q == 4'b1000 ? 4'b0100 :
                         sel_q == 4'b0100 ? 4'b0010 :
                         sel_q == 4'b0010 ? 4'b0001 : 4'b1000;
            if (take) begin
                state_q  <= nxt ? OWN1 : OWN0;
                gnt_q    <= nxt ? 2'b10 : 2'b01;
                shadow_q <= nxt ? data1 : data0;
                hold_q   <= '0;
                ptr_q    <= !nxt;
            end else if (state_q != IDLE && frame_end) begin
                if (keep) begin
                    shadow_q <= own_id ? data1 : data0;
                    hold_q   <= hold_d;
                end else begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            end
        end
    end
    assign b3      = blank_en && shadow_q[15:12] == 4'h0;
    assign b2      = b3 && shadow_q[11:8] == 4'h0;
    assign b1      = b2 && shadow_q[7:4] == 4'h0;
    assign segment = state_q == IDLE ? 4'h0 :
                     sel_q == 4'b1000 ? (b3 ? 4'hF : shadow_q[15:12]) :
                     sel_q == 4'b0100 ? (b2 ? 4'hF : shadow_q[11:8]) :
                     sel_q == 4'b0010 ? (b1 ? 4'hF : shadow_q[7:4]) :
                     sel_q == 4'b0001 ? shadow_q[3:0] : 4'h0;
    assign gnt     = gnt_q;
    assign select  = sel_q;
endmodule

// File: tb/tb_disp_scheduler.sv
// tb_disp_scheduler: directed cases plus random traffic against an integer-level model
// that tracks elapsed cycles, tick count and the current owner.
module tb_disp_scheduler;
    localparam int SD = 4;
    localparam int HF = 2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        blank_en = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  gnt;
    logic [15:0] data0 = 16'h0;
    logic [15:0] data1 = 16'h0;
    logic [3:0]  select, segment;
    logic        frame_end;
    int checks = 0;
    int failures = 0;
    int cyc, ticks, owner, hold, last;
    logic [15:0] shadow;

    disp_scheduler #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
        .blank_en(blank_en), .gnt(gnt), .select(select), .segment(segment),
        .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_select();
        return ticks == 0 ? 4'b0000 : 4'(4'b1000 >> ((ticks - 1) % 4));
    endfunction

    function automatic bit m_fe();
        return (cyc % SD) == SD - 1 && m_select() == 4'b0001;
    endfunction

    // digit position comes from how many ticks have elapsed; a digit is a leading zero
    // exactly when everything from the left edge down to it is zero
    function automatic logic [3:0] m_segment();
        int sh;
        if (owner < 0 || ticks == 0) return 4'h0;
        sh = 4 * (3 - (ticks - 1) % 4);
        if (blank_en && sh > 0 && (shadow >> sh) == 16'h0) return 4'hF;
        return 4'(shadow >> sh);
    endfunction

    task automatic m_reset();
        cyc = 0; ticks = 0; owner = -1; hold = 0; last = 1; shadow = 16'h0;
    endtask

    task automatic m_grant(input int i);
        owner = i; last = i; hold = 0;
        shadow = i != 0 ? data1 : data0;
    endtask

    task automatic m_step();
        bit fe;
        int o, hn;
        fe = m_fe();
        o = owner;
        hn = hold + 1 > HF ? HF : hold + 1;
        if (o < 0) begin
            if (req != 2'b00) m_grant(req == 2'b11 ? (last == 0 ? 1 : 0) : (req[1] ? 1 : 0));
        end else if (fe) begin
            if (req[o] && !(req[1 - o] && hn == HF)) begin
                shadow = o != 0 ? data1 : data0;
                hold = hn;
            end else if (req[1 - o]) m_grant(1 - o);
            else owner = -1;
        end
        if ((cyc % SD) == SD - 1) ticks++;
        cyc++;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".gnt"}, 16'(gnt), 16'(owner < 0 ? 0 : 1 << owner));
        check({tag, ".select"}, 16'(select), 16'(m_select()));
        check({tag, ".segment"}, 16'(segment), 16'(m_segment()));
        check({tag, ".frame_end"}, 16'(frame_end), 16'(m_fe()));
    endtask

    task automatic cycle(input string tag, input int n);
        repeat (n) begin
            m_step();
            @(posedge clk);
            @(negedge clk);
            compare_all(tag);
        end
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        m_reset();
        #1 compare_all("arst");
        @(negedge clk);
        compare_all("arst_hold");
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_data();
        logic [15:0] d;
        int k;
        d = 16'h0;
        for (int i = 0; i < 4; i++) d = {d[11:0], 4'($urandom_range(0, 9))};
        k = $urandom_range(0, 4);
        return k == 0 ? d : d & 16'(16'hFFFF >> (4 * k));
    endfunction

    initial begin
        m_reset();
        @(negedge clk);
        compare_all("por");
        @(negedge clk);
        compare_all("por2");
        rst_n = 1'b1;
        req = 2'b01; data0 = 16'h1234;
        cycle("c1", 24);
        cycle("c2a", 2);
        data0 = 16'h5678;
        cycle("c2", 20);
        cycle("c4a", 3);
        req = 2'b00;
        cycle("c4", 20);
        pulse_reset();
        req = 2'b11; data0 = 16'h1111; data1 = 16'h2222;
        cycle("c3", 90);
        pulse_reset();
        req = 2'b01; blank_en = 1'b1; data0 = 16'h0070;
        cycle("c5a", 20);
        data0 = 16'h0000;
        cycle("c5b", 20);
        blank_en = 1'b0;
        cycle("c5c", 8);
        req = 2'b10; data1 = 16'h9876;
        cycle("c6a", 18);
        pulse_reset();
        req = 2'b11;
        cycle("c6", 12);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) req = 2'($urandom);
            if ($urandom_range(0, 3) == 0) data0 = rand_data();
            if ($urandom_range(0, 3) == 0) data1 = rand_data();
            if ($urandom_range(0, 15) == 0) blank_en = 1'($urandom);
            if ($urandom_range(0, 399) == 0) pulse_reset();
            cycle("rnd", 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/disp_scheduler.md
DISP_SCHEDULER -- requirements
Module: disp_scheduler

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 32: scan-tick period in clk cycles (legal range 2..65535).
REQ-002 SHALL have parameter HOLD_FRAMES, default 4: minimum number of full scan frames an owner keeps the display before it can be preempted (legal range 1..15).
REQ-003 SHALL have port clk, input, 1: single clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port req, input, 2: display request, req[i] from requester i, level-sensitive.
REQ-006 SHALL have ports data0 and data1, input, 16 each: four BCD digits per requester, [15:12] being the leftmost digit.
REQ-007 SHALL have port blank_en, input, 1: enables leading-zero blanking.
REQ-008 SHALL have port gnt, output, 2: one-hot or zero; gnt[i] indicates requester i owns the display.
REQ-009 SHALL have port select, output, 4: one-hot digit enable.
REQ-010 SHALL have port segment, output, 4: digit code for the selected digit.
REQ-011 SHALL have port frame_end, output, 1: one-cycle pulse at the last tick of each frame.

Function
REQ-012 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; tick SHALL assert for the cycle in which the counter equals SCAN_DIV-1.
REQ-013 select SHALL advance only on tick: 1000->0100->0010->0001->1000; any other value SHALL go to 1000 on the next tick.
REQ-014 frame_end SHALL equal tick AND select==0001, so one frame is 4 ticks.
REQ-015 FSM SHALL have three states: IDLE, OWN0 and OWN1; gnt SHALL be 00, 01 and 10 respectively, registered.
REQ-016 IDLE: if req!=00, the FSM SHALL enter OWNi on the next clk, without waiting for a frame boundary.
REQ-017 Selection in IDLE SHALL use a 1-bit round-robin pointer that favours the requester not granted last; after reset the pointer SHALL favour requester 0.
REQ-018 On entry to OWNi, the shadow register SHALL load datai, and the hold counter SHALL clear.
REQ-019 While in OWNi, the shadow SHALL reload from datai only at frame_end, so no mid-frame tearing occurs.
REQ-020 The hold counter SHALL increment at each frame_end while owned, saturating at HOLD_FRAMES.
REQ-021 Release: if req[i]==0 at frame_end in OWNi, the FSM SHALL go to OWNj when req[j]==1, else to IDLE.
REQ-022 Preemption: if req[i]==1, req[j]==1 and the hold counter equals HOLD_FRAMES at frame_end, the FSM SHALL switch to OWNj, load datajand clear the hold counter.
REQ-023 A req drop and re-raise between frame_ends SHALL NOT be observed; sampling of req SHALL occur only at frame_end in OWN states.
REQ-024 Digit mapping SHALL be 1000->shadow[15:12], 0100->[11:8], 0010->[7:4] and 0001->[3:0]; segment SHALL be combinational from select and shadow.
REQ-025 When blank_en=1, leading zero digits SHALL output 4'hF; the rightmost digit SHALL never be blanked.
REQ-026 In IDLE, or when select is not one-hot, segment SHALL be 4'h0.
REQ-027 The scan counter and select SHALL run regardless of FSM state.

Reset
REQ-028 While rst_n=0, the block SHALL hold: scan counter 0, select 0000, state IDLE, gnt 00, shadow 0000, hold counter 0, pointer favouring requester 0, frame_end 0 and segment 4'h0.
REQ-029 Reset asserted mid-frame or mid-ownership SHALL return all state to REQ-028 values immediately; after release, the first tick SHALL occur SCAN_DIV cycles later and SHALL set select to 1000.

Verification
REQ-030 Case 1: reset, then req=01 and data0=16'h1234 with SCAN_DIV=4 -> gnt=01 one clk later; select cycles 1000,0100,0010,0001 every 4 clks; segment shows 1,2,3,4.
REQ-031 Case 2: owner 0 with data0 changed to 16'h5678 mid-frame -> segment keeps showing 1234 until frame_end, then shows 5678.
REQ-032 Case 3: req=11 from IDLE after reset with HOLD_FRAMES=2 -> gnt=01; after 2 frame_ends, switch to gnt=10 at that frame_end; after 2 more frame_ends, return to gnt=01.
REQ-033 Case 4: owner 0 drops req mid-frame while req[1]=0 -> gnt stays 01 until frame_end, then becomes 00 and segment becomes 0.
REQ-034 Case 5: blank_en=1 with data=16'h0070 -> segment sequence F,F,7,0; with data=16'h0000 -> sequence F,F,F,0.
REQ-035 Case 6: rst_n pulsed low while gnt=10 mid-frame -> gnt=00, select=0000 asynchronously; after release, select=1000 after SCAN_DIV clks, and the pointer favours requester 0.
